// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the Hamming SECDED stream decoder.
package hamming_pkg;

  // Per-word decode outcome reported alongside the corrected data.
  typedef enum logic [1:0] {
    ERR_OK            = 2'd0,
    ERR_CORRECTED     = 2'd1,
    ERR_UNCORRECTABLE = 2'd2
  } err_status_t;

  // Full codeword width: Hamming positions 1..2**p-1 plus overall parity at bit 0.
  function automatic int code_width(input int p);
    return 1 << p;
  endfunction

  // Payload width: every codeword position that is not a power of two.
  function automatic int data_width(input int p);
    return (1 << p) - p - 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 2**P-bit codeword.
module hamming_syndrome #(
  parameter int P = 3
) (
  input  logic [(2**P)-1:0] i_code,
  output logic [P-1:0]      o_syn,
  output logic              o_par
);

  // Syndrome bit j folds every Hamming position whose index has bit j set;
  // overall parity covers all bits including bit 0.
  always_comb begin
    o_syn = '0;
    for (int i = 1; i < (2**P); i++) begin
      for (int j = 0; j < P; j++) begin
        if (((i >> j) & 1) != 0) begin
          o_syn[j] = o_syn[j] ^ i_code[i];
        end
      end
    end
    o_par = ^i_code;
  end

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready streaming and
// saturating corrected/uncorrectable word counters.
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both high. Stage 2 advances when it is empty or the
// consumer is ready (w_adv2); stage 1 accepts when it is empty or stage 2
// advances, so in_ready depends combinationally on out_ready. A producer may
// not retract valid or change data while valid && !ready; the decoder holds
// its outputs stable under the same condition.
module hamming_secded_stream_decoder
  import hamming_pkg::*;
#(
  parameter int P  = 3,
  parameter int CW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [(2**P)-1:0]         rx_code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(2**P)-P-2:0]       ec_data,
  output logic [1:0]                err_status,
  output logic [P-1:0]              err_pos,
  input  logic                      cnt_clr,
  output logic [CW-1:0]             corr_count,
  output logic [CW-1:0]             uncorr_count
);

  localparam int N = code_width(P);
  localparam int K = data_width(P);

  // Stage 1: raw codeword with its syndrome and parity.
  logic          r_valid1;
  logic [N-1:0]  r_code1;
  logic [P-1:0]  r_syn1;
  logic          r_par1;

  // Stage 2: decoded result presented to the consumer.
  logic          r_out_valid;
  logic [K-1:0]  r_ec_data;
  err_status_t   r_err_status;
  logic [P-1:0]  r_err_pos;

  logic [CW-1:0] r_corr_count;
  logic [CW-1:0] r_uncorr_count;

  logic [P-1:0]  w_syn;
  logic          w_par;
  logic          w_adv2;
  logic          w_in_ready;
  logic          w_load2;
  err_status_t   w_status;
  logic [N-1:0]  w_fixed;
  logic [K-1:0]  w_data;

  hamming_syndrome #(.P(P)) u_syndrome (
    .i_code (rx_code),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  assign w_adv2     = !r_out_valid || out_ready;
  assign w_in_ready = !r_valid1 || w_adv2;
  assign w_load2    = w_adv2 && r_valid1;

  // Classify the stage-1 word and flip the single bad position when the
  // parity says exactly one bit is wrong. A zero syndrome with odd parity
  // means only the overall-parity bit flipped, so the payload is untouched.
  always_comb begin
    w_status = ERR_OK;
    w_fixed  = r_code1;
    if (r_par1) begin
      w_status = ERR_CORRECTED;
      if (r_syn1 != '0) begin
        w_fixed[r_syn1] = ~r_code1[r_syn1];
      end
    end else if (r_syn1 != '0) begin
      w_status = ERR_UNCORRECTABLE;
    end
  end

  // Gather non-power-of-two positions in ascending order; shifting in from the
  // top leaves the lowest such position at data bit 0 (needs P >= 3).
  always_comb begin
    w_data = '0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        w_data = {w_fixed[i], w_data[K-1:1]};
      end
    end
  end

  // Stage 1 register: capture a new codeword whenever the slot can be refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid1 <= 1'b0;
      r_code1  <= '0;
      r_syn1   <= '0;
      r_par1   <= 1'b0;
    end else if (w_in_ready) begin
      r_valid1 <= in_valid;
      if (in_valid) begin
        r_code1 <= rx_code;
        r_syn1  <= w_syn;
        r_par1  <= w_par;
      end
    end
  end

  // Stage 2 register: take the decoded stage-1 word when the output is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_ec_data    <= '0;
      r_err_status <= ERR_OK;
      r_err_pos    <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_valid1;
      if (r_valid1) begin
        r_ec_data    <= w_data;
        r_err_status <= w_status;
        r_err_pos    <= r_syn1;
      end
    end
  end

  // Error statistics: count on load into stage 2, saturate, clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (w_load2) begin
      if (w_status == ERR_CORRECTED && r_corr_count != '1) begin
        r_corr_count <= r_corr_count + 1'b1;
      end
      if (w_status == ERR_UNCORRECTABLE && r_uncorr_count != '1) begin
        r_uncorr_count <= r_uncorr_count + 1'b1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign ec_data      = r_ec_data;
  assign err_status   = r_err_status;
  assign err_pos      = r_err_pos;
  assign corr_count   = r_corr_count;
  assign uncorr_count = r_uncorr_count;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Bench for hamming_secded_stream_decoder at P=3, CW=2 (small counter width so
// saturation is reachable quickly).
module tb_hamming_secded_stream_decoder;

  localparam int P  = 3;
  localparam int CW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    rx_code;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    ec_data;
  logic [1:0]    err_status;
  logic [2:0]    err_pos;
  logic          cnt_clr;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  always #5 clk = ~clk;

  hamming_secded_stream_decoder #(.P(P), .CW(CW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rx_code      (rx_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ec_data      (ec_data),
    .err_status   (err_status),
    .err_pos      (err_pos),
    .cnt_clr      (cnt_clr),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];     // {data[3:0], status[1:0], pos[2:0]}
  int         corr_m = 0;
  int         unc_m  = 0;
  logic       rand_done;

  typedef struct {
    logic [7:0] rx;
    logic [3:0] d;
    logic [1:0] st;
    logic [2:0] pos;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Syndrome as the XOR of the indices of all set Hamming positions.
  function automatic logic [8:0] ref_decode(input logic [7:0] c);
    int         s;
    int         ones;
    logic [7:0] f;
    logic [1:0] st;
    logic [3:0] d;
    s = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin
        ones++;
        if (i != 0) s = s ^ i;
      end
    end
    f = c;
    if ((ones % 2) == 1 && s != 0) f[s] = ~f[s];
    if (s == 0 && (ones % 2) == 0)      st = 2'd0;
    else if ((ones % 2) == 1)           st = 2'd1;
    else                                st = 2'd2;
    d = {f[7], f[6], f[5], f[3]};
    return {d, st, 3'(s)};
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int         s;
    c = 8'd0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    s = 0;
    for (int i = 1; i < 8; i++) if (c[i]) s = s ^ i;
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[0] = ^c;
    return c;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Present one word from a falling edge and hold it until it is accepted.
  task automatic push_word(input logic [7:0] code, input logic [8:0] expw);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    rx_code  = code;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_in_time", 32'(acc), 32'(1));
    if (acc) begin
      exp_q.push_back(expw);
      if (expw[4:3] == 2'd1) corr_m = sat_inc(corr_m);
      if (expw[4:3] == 2'd2) unc_m  = sat_inc(unc_m);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic set_ordy(input logic v);
    @(posedge clk);
    #2 out_ready = v;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic clear_cnt();
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    corr_m = 0;
    unc_m  = 0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_corr"},   32'(corr_count),   32'(corr_m));
    chk({tag, "_uncorr"}, 32'(uncorr_count), 32'(unc_m));
  endtask

  // ---------------- output monitor ----------------
  // Every transfer on the output side must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h with no word pending", {ec_data, err_status, err_pos});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("out_word", 32'({ec_data, err_status, err_pos}), 32'(e));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] a_code, b_code, c_code, code;
    logic [3:0] d;
    int         nerr, pa, pb;

    tbl[0] = '{rx: 8'b00010000, d: 4'b0000, st: 2'd1, pos: 3'd4};
    tbl[1] = '{rx: 8'b11111101, d: 4'b1111, st: 2'd1, pos: 3'd1};
    tbl[2] = '{rx: 8'b00000001, d: 4'b0000, st: 2'd1, pos: 3'd0};
    tbl[3] = '{rx: 8'b00000110, d: 4'b0000, st: 2'd2, pos: 3'd3};
    tbl[4] = '{rx: 8'b00000000, d: 4'b0000, st: 2'd0, pos: 3'd0};
    tbl[5] = '{rx: 8'b11111111, d: 4'b1111, st: 2'd0, pos: 3'd0};
    tbl[6] = '{rx: 8'b10101010, d: 4'b1011, st: 2'd0, pos: 3'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    rx_code   = 8'd0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    rand_done = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),    32'(0));
    chk("rst_in_ready",   32'(in_ready),     32'(1));
    chk("rst_ec_data",    32'(ec_data),      32'(0));
    chk("rst_err_status", 32'(err_status),   32'(0));
    chk("rst_err_pos",    32'(err_pos),      32'(0));
    chk("rst_corr",       32'(corr_count),   32'(0));
    chk("rst_uncorr",     32'(uncorr_count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Two register stages: nothing visible after the accepting edge, valid one edge later.
    set_ordy(1'b1);
    push_word(8'b10101010, {4'b1011, 2'd0, 3'd0});
    @(negedge clk);
    chk("lat_after_accept", 32'(out_valid), 32'(0));
    @(negedge clk);
    chk("lat_next_edge", 32'(out_valid), 32'(1));
    drain();

    // Directed vector table, one word at a time, counters checked after each.
    clear_cnt();
    for (int i = 0; i < 7; i++) begin
      push_word(tbl[i].rx, {tbl[i].d, tbl[i].st, tbl[i].pos});
      drain();
      chk_counters($sformatf("tbl%0d", i));
    end

    // Backpressure: two words fill the pipe, the third waits, outputs hold.
    a_code = 8'b10101010;
    b_code = 8'b00010000;
    c_code = 8'b00000110;
    set_ordy(1'b0);
    push_word(a_code, ref_decode(a_code));
    push_word(b_code, ref_decode(b_code));
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rx_code  = c_code;
      chk("bp_in_ready_low",  32'(in_ready),  32'(0));
      chk("bp_out_valid",     32'(out_valid), 32'(1));
      chk("bp_hold_a",        32'({ec_data, err_status, err_pos}), 32'(ref_decode(a_code)));
      chk("bp_pending_two",   32'(exp_q.size()), 32'(2));
    end
    set_ordy(1'b1);
    push_word(c_code, ref_decode(c_code));
    drain();

    // Randomized traffic with random output stalls against the model.
    clear_cnt();
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          d    = 4'($urandom_range(0, 15));
          code = encode(d);
          nerr = $urandom_range(0, 2);
          pa   = $urandom_range(0, 7);
          pb   = (pa + $urandom_range(1, 7)) % 8;
          if (nerr >= 1) code[pa] = ~code[pa];
          if (nerr == 2) code[pb] = ~code[pb];
          push_word(code, ref_decode(code));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    set_ordy(1'b1);
    drain();
    chk_counters("rand");

    // Saturation at 2**CW-1, then a clear landing on the same edge as a load.
    clear_cnt();
    for (int n = 0; n < 5; n++) push_word(8'b00010000, ref_decode(8'b00010000));
    drain();
    chk("sat_corr_three", 32'(corr_count), 32'(3));
    push_word(8'b00010000, ref_decode(8'b00010000));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    corr_m = 0;
    unc_m  = 0;
    chk("clr_wins_corr", 32'(corr_count), 32'(0));
    drain();
    chk_counters("after_clr");

    // Reset in the middle of a stalled stream discards both words.
    set_ordy(1'b0);
    push_word(a_code, ref_decode(a_code));
    push_word(b_code, ref_decode(b_code));
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid",  32'(out_valid),  32'(0));
    chk("mid_rst_in_ready",   32'(in_ready),   32'(1));
    chk("mid_rst_err_status", 32'(err_status), 32'(0));
    chk("mid_rst_ec_data",    32'(ec_data),    32'(0));
    chk("mid_rst_corr",       32'(corr_count), 32'(0));
    exp_q.delete();
    corr_m = 0;
    unc_m  = 0;
    rst = 1'b0;

    // Decoder resumes cleanly after the reset.
    set_ordy(1'b1);
    push_word(8'b11111101, ref_decode(8'b11111101));
    drain();
    chk_counters("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
